// File: rtl/corral_pkg.sv
// Shared types and helpers for the Corral game engine: directions, FSM states,
// grid positions and the Manhattan distance used to score horse moves.
package corral_pkg;

  typedef logic [3:0] pos_t;

  typedef enum logic [2:0] {
    DIR_N, DIR_NE, DIR_E, DIR_SE, DIR_S, DIR_SW, DIR_W, DIR_NW
  } dir_t;

  typedef enum logic [1:0] {
    ST_OVER, ST_IDLE, ST_COWBOY, ST_SCAN
  } state_t;

  localparam int unsigned DIR_COUNT = 8;
  localparam int unsigned SCAN_LAST = 8;

  function automatic logic [2:0] manhattan(input pos_t a, input pos_t b);
    logic [1:0] dr;
    logic [1:0] dc;
    dr = (a[3:2] > b[3:2]) ? a[3:2] - b[3:2] : b[3:2] - a[3:2];
    dc = (a[1:0] > b[1:0]) ? a[1:0] - b[1:0] : b[1:0] - a[1:0];
    return {1'b0, dr} + {1'b0, dc};
  endfunction

endpackage

// File: rtl/corral_step.sv
// One-cell step on the 4x4 grid; off-grid steps report on_grid_o=0 and
// return the original position unchanged.
module corral_step
  import corral_pkg::*;
(
  input  pos_t       pos_i,
  input  dir_t       dir_i,
  output pos_t       next_pos_o,
  output logic       on_grid_o
);

  // Extra MSB catches both underflow (0-1) and overflow (3+1).
  logic [2:0] row;
  logic [2:0] col;

  always_comb begin
    row = {1'b0, pos_i[3:2]};
    col = {1'b0, pos_i[1:0]};
    unique case (dir_i)
      DIR_N:  row = row - 3'd1;
      DIR_NE: begin row = row - 3'd1; col = col + 3'd1; end
      DIR_E:  col = col + 3'd1;
      DIR_SE: begin row = row + 3'd1; col = col + 3'd1; end
      DIR_S:  row = row + 3'd1;
      DIR_SW: begin row = row + 3'd1; col = col - 3'd1; end
      DIR_W:  col = col - 3'd1;
      DIR_NW: begin row = row - 3'd1; col = col - 3'd1; end
    endcase
  end

  assign on_grid_o  = ~row[2] & ~col[2];
  assign next_pos_o = on_grid_o ? {row[1:0], col[1:0]} : pos_i;

endmodule

// File: rtl/corral_engine.sv
// Corral game core: cowboy step, then a 9-cycle sequential horse flee search.
// Define CORRAL_MOVE_LIMIT_EN to build the move counter and MAX_MOVES loss rule.
module corral_engine
  import corral_pkg::*;
#(
  parameter int unsigned MAX_MOVES    = 12,
  parameter pos_t        START_COWBOY = 4'h0,
  parameter pos_t        START_HORSE  = 4'hF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enter,
  input  logic [2:0] move,
  output logic [3:0] cowboy_pos,
  output logic [3:0] horse_pos,
  output logic       gameover,
  output logic       lostwon,
  output logic       ready
);

  if (MAX_MOVES < 1 || MAX_MOVES > 15) begin : g_bad_max_moves
    $error("corral_engine: MAX_MOVES out of range 1..15");
  end
  if (START_COWBOY == START_HORSE) begin : g_bad_start
    $error("corral_engine: START_COWBOY must differ from START_HORSE");
  end

  state_t     state_q, state_d;
  pos_t       cowboy_q, cowboy_d;
  pos_t       horse_q, horse_d;
  logic       gameover_q, gameover_d;
  logic       lostwon_q, lostwon_d;
  logic       ready_q, ready_d;
  dir_t       dir_q, dir_d;
  logic [3:0] k_q, k_d;
  pos_t       best_q, best_d;
  logic [2:0] best_score_q, best_score_d;
`ifdef CORRAL_MOVE_LIMIT_EN
  logic [3:0] cnt_q, cnt_d;
`endif

  pos_t       cow_next;
  logic       cow_on_grid;
  dir_t       cand_dir;
  pos_t       cand_pos;
  logic       cand_on_grid;

  corral_step u_cow_step (
    .pos_i      (cowboy_q),
    .dir_i      (dir_q),
    .next_pos_o (cow_next),
    .on_grid_o  (cow_on_grid)
  );

  // Candidate k (1..8) maps to direction k-1; the 3-bit wrap turns k=8 into NW.
  assign cand_dir = dir_t'(k_q[$clog2(DIR_COUNT)-1:0] - 3'd1);

  corral_step u_scan_step (
    .pos_i      (horse_q),
    .dir_i      (cand_dir),
    .next_pos_o (cand_pos),
    .on_grid_o  (cand_on_grid)
  );

  logic       cand_is_stay;
  pos_t       cand;
  logic       cand_valid;
  logic [2:0] cand_score;
  logic       take;
  pos_t       pick;
  logic [2:0] pick_score;
  pos_t       cow_new;

  always_comb begin
    cand_is_stay = (k_q == '0);
    cand         = cand_is_stay ? horse_q : cand_pos;
    cand_valid   = cand_is_stay | (cand_on_grid & (cand_pos != cowboy_q));
    cand_score   = manhattan(cand, cowboy_q);
    // Stay seeds the running best; later candidates need a strictly better score.
    take         = cand_is_stay | (cand_valid & (cand_score > best_score_q));
    pick         = take ? cand : best_q;
    pick_score   = take ? cand_score : best_score_q;
    cow_new      = cow_on_grid ? cow_next : cowboy_q;
  end

  always_comb begin
    state_d      = state_q;
    cowboy_d     = cowboy_q;
    horse_d      = horse_q;
    gameover_d   = gameover_q;
    lostwon_d    = lostwon_q;
    ready_d      = ready_q;
    dir_d        = dir_q;
    k_d          = k_q;
    best_d       = best_q;
    best_score_d = best_score_q;
`ifdef CORRAL_MOVE_LIMIT_EN
    cnt_d        = cnt_q;
`endif
    unique case (state_q)
      ST_OVER: begin
        if (enter) begin
          cowboy_d   = START_COWBOY;
          horse_d    = START_HORSE;
          gameover_d = 1'b0;
          lostwon_d  = 1'b0;
          state_d    = ST_IDLE;
`ifdef CORRAL_MOVE_LIMIT_EN
          cnt_d      = '0;
`endif
        end
      end
      ST_IDLE: begin
        if (enter) begin
          dir_d   = dir_t'(move);
          ready_d = 1'b0;
          state_d = ST_COWBOY;
        end
      end
      ST_COWBOY: begin
        cowboy_d = cow_new;
        k_d      = '0;
`ifdef CORRAL_MOVE_LIMIT_EN
        cnt_d    = cnt_q + 4'd1;
`endif
        if (cow_new == horse_q) begin
          gameover_d = 1'b1;
          lostwon_d  = 1'b1;
          ready_d    = 1'b1;
          state_d    = ST_OVER;
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        best_d       = pick;
        best_score_d = pick_score;
        k_d          = k_q + 4'd1;
        if (k_q == 4'(SCAN_LAST)) begin
          horse_d = pick;
          ready_d = 1'b1;
          k_d     = '0;
          state_d = ST_IDLE;
`ifdef CORRAL_MOVE_LIMIT_EN
          if (cnt_q == 4'(MAX_MOVES)) begin
            gameover_d = 1'b1;
            lostwon_d  = 1'b0;
            state_d    = ST_OVER;
          end
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_OVER;
      cowboy_q     <= START_COWBOY;
      horse_q      <= START_HORSE;
      gameover_q   <= 1'b1;
      lostwon_q    <= 1'b0;
      ready_q      <= 1'b1;
      dir_q        <= DIR_N;
      k_q          <= '0;
      best_q       <= '0;
      best_score_q <= '0;
`ifdef CORRAL_MOVE_LIMIT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cowboy_q     <= cowboy_d;
      horse_q      <= horse_d;
      gameover_q   <= gameover_d;
      lostwon_q    <= lostwon_d;
      ready_q      <= ready_d;
      dir_q        <= dir_d;
      k_q          <= k_d;
      best_q       <= best_d;
      best_score_q <= best_score_d;
`ifdef CORRAL_MOVE_LIMIT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign cowboy_pos = cowboy_q;
  assign horse_pos  = horse_q;
  assign gameover   = gameover_q;
  assign lostwon    = lostwon_q;
  assign ready      = ready_q;

endmodule
